// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and default MD latencies for the pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_MD = 2'd1,
    FLUSH   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

endpackage

// File: rtl/pipe_ctrl_md_busy_cnt.sv
// Multiply/divide occupancy counter; loads on an accepted md_start and counts down to idle.
module md_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic             md_busy
);

  logic accept;
  logic load;

  // hold marks the EX instruction as being killed, so its start never reaches the unit
  assign accept  = md_start & ~hold;
  assign load    = accept & (cnt == '0);
  assign md_busy = (cnt != '0) | accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline enable/clear sequencing: stalls, interrupt flush and eret redirect.
// Build option PIPE_CTRL_MD_EN adds the MD busy counter and the WAIT_MD drain state.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load_use,
  input  logic md_use,
  input  logic md_start,
  input  logic md_is_div,
  input  logic irq_req,
  input  logic eret_d,
  output logic en_pc,
  output logic en_fd,
  output logic clr_fd,
  output logic clr_de,
  output logic clr_em,
  output logic clr_mw,
  output logic pc_sel_exc,
  output logic pc_sel_epc,
  output logic irq_ack,
  output logic md_busy
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             stall;

`ifdef PIPE_CTRL_MD_EN
  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_busy_cnt (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .hold      (state == FLUSH),
    .cnt       (cnt),
    .md_busy   (md_busy)
  );
`else
  // With no MD unit the counter reads as permanently idle, so WAIT_MD is unreachable
  logic unused_md;
  assign cnt       = '0;
  assign md_busy   = 1'b0;
  assign unused_md = ^{md_start, md_is_div, (MULT_CYC != DIV_CYC)};
`endif

  assign stall = load_use | (md_busy & md_use);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= RUN;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (irq_req) next_state = (cnt == '0) ? FLUSH : WAIT_MD;
      // leave on the edge where the counter reaches zero so FLUSH sees an idle unit
      WAIT_MD: if (cnt <= CNT_W'(1)) next_state = FLUSH;
      FLUSH:   next_state = RECOVER;
      RECOVER: next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    en_pc      = 1'b0;
    en_fd      = 1'b0;
    clr_fd     = 1'b0;
    clr_de     = 1'b0;
    clr_em     = 1'b0;
    clr_mw     = 1'b0;
    pc_sel_exc = 1'b0;
    pc_sel_epc = 1'b0;
    irq_ack    = 1'b0;
    case (state)
      FLUSH: begin
        en_pc      = 1'b1;
        pc_sel_exc = 1'b1;
        irq_ack    = 1'b1;
        clr_fd     = 1'b1;
        clr_de     = 1'b1;
        clr_em     = 1'b1;
      end
      WAIT_MD: clr_de = 1'b1;
      default: begin
        if (stall) begin
          clr_de = 1'b1;
        end else if (eret_d) begin
          en_pc      = 1'b1;
          en_fd      = 1'b1;
          pc_sel_epc = 1'b1;
          clr_fd     = 1'b1;
        end else begin
          en_pc = 1'b1;
          en_fd = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Cycle-by-cycle vector bench for pipe_ctrl; MD rows run only when PIPE_CTRL_MD_EN is defined.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_use = 1'b0, md_use = 1'b0, md_start = 1'b0, md_is_div = 1'b0;
  logic irq_req = 1'b0, eret_d = 1'b0;
  logic en_pc, en_fd, clr_fd, clr_de, clr_em, clr_mw;
  logic pc_sel_exc, pc_sel_epc, irq_ack, md_busy;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .load_use   (load_use),
    .md_use     (md_use),
    .md_start   (md_start),
    .md_is_div  (md_is_div),
    .irq_req    (irq_req),
    .eret_d     (eret_d),
    .en_pc      (en_pc),
    .en_fd      (en_fd),
    .clr_fd     (clr_fd),
    .clr_de     (clr_de),
    .clr_em     (clr_em),
    .clr_mw     (clr_mw),
    .pc_sel_exc (pc_sel_exc),
    .pc_sel_epc (pc_sel_epc),
    .irq_ack    (irq_ack),
    .md_busy    (md_busy)
  );

  // inputs: {load_use, md_use, md_start, md_is_div, irq_req, eret_d}
  localparam logic [5:0] I0  = 6'b000000;
  localparam logic [5:0] LU  = 6'b100000;
  localparam logic [5:0] MU  = 6'b010000;
  localparam logic [5:0] MS  = 6'b001000;
  localparam logic [5:0] DV  = 6'b000100;
  localparam logic [5:0] IRQ = 6'b000010;
  localparam logic [5:0] ER  = 6'b000001;

  // outputs: {en_pc, en_fd, clr_fd, clr_de, clr_em, clr_mw, pc_sel_exc, pc_sel_epc, irq_ack, md_busy}
  localparam logic [9:0] NORM  = 10'b1100000000;
  localparam logic [9:0] STALL = 10'b0001000000;
  localparam logic [9:0] ERET  = 10'b1110000100;
  localparam logic [9:0] FLSH  = 10'b1011101010;
  localparam logic [9:0] B     = 10'b0000000001;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb_exp[$];
  string      sb_name[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic void add(string name, logic rst, logic [5:0] in, logic [9:0] exp);
    vec_t v;
    v.name = name;
    v.rst  = rst;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endfunction

  task automatic step(input vec_t v);
    logic [9:0] got;
    logic [9:0] exp;
    string      nm;
    @(posedge clk);
    #1;
    reset = v.rst;
    {load_use, md_use, md_start, md_is_div, irq_req, eret_d} = v.in;
    sb_exp.push_back(v.exp);
    sb_name.push_back(v.name);
    @(negedge clk);
    got = {en_pc, en_fd, clr_fd, clr_de, clr_em, clr_mw, pc_sel_exc, pc_sel_epc, irq_ack, md_busy};
    exp = sb_exp.pop_front();
    nm  = sb_name.pop_front();
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  initial begin
    // shared control rows
    add("reset_release",   1'b0, I0,      NORM);
    add("load_use",        1'b0, LU,      STALL);
    add("after_load_use",  1'b0, I0,      NORM);
    add("eret_with_lu",    1'b0, ER | LU, STALL);
    add("eret_alone",      1'b0, ER,      ERET);
    add("idle",            1'b0, I0,      NORM);
    add("irq_run",         1'b0, IRQ,     NORM);
    add("irq_flush",       1'b0, IRQ,     FLSH);
    add("irq_recover",     1'b0, IRQ,     NORM);
    add("irq_dropped",     1'b0, I0,      NORM);
    add("irq_with_lu",     1'b0, IRQ | LU, STALL);
    add("flush_over_lu",   1'b0, LU,      FLSH);
    add("recover_eret",    1'b0, ER,      ERET);
    add("run_again",       1'b0, I0,      NORM);
    add("irq2_run",        1'b0, IRQ,     NORM);
    add("flush_over_eret", 1'b0, ER,      FLSH);
    add("recover_idle",    1'b0, I0,      NORM);
    // reset mid-FLUSH abandons the acknowledge
    add("pre_rst_irq",     1'b0, IRQ,     NORM);
    add("rst_in_flush",    1'b1, I0,      NORM);
    add("post_rst_flush",  1'b0, I0,      NORM);
    add("post_rst_flush2", 1'b0, I0,      NORM);
`ifdef PIPE_CTRL_MD_EN
    add("div_start", 1'b0, MS | DV | MU, STALL | B);
    for (int unsigned k = 1; k <= 10; k++) add($sformatf("div_busy_%0d", k), 1'b0, MU, STALL | B);
    add("div_done",        1'b0, MU,      NORM);
    add("mult_start",      1'b0, MS,      NORM | B);
    add("mult_irq",        1'b0, IRQ,     NORM | B);
    for (int unsigned k = 2; k <= 5; k++) add($sformatf("wait_md_%0d", k), 1'b0, I0, STALL | B);
    add("mult_flush",      1'b0, I0,      FLSH);
    add("mult_recover",    1'b0, I0,      NORM);
    add("mult_run",        1'b0, I0,      NORM);
    add("fl_irq",          1'b0, IRQ,     NORM);
    add("start_in_flush",  1'b0, MS | MU, FLSH);
    add("no_load_flush",   1'b0, MU,      NORM);
    add("busy_start",      1'b0, MS,      NORM | B);
    add("restart_ignored", 1'b0, MS | DV, NORM | B);
    for (int unsigned k = 2; k <= 5; k++) add($sformatf("mult_cnt_%0d", k), 1'b0, I0, NORM | B);
    add("mult_idle",       1'b0, I0,      NORM);
`else
    add("md_ignored",      1'b0, MS | DV | MU, NORM);
    add("md_irq",          1'b0, IRQ | MS, NORM);
    add("md_direct_flush", 1'b0, I0,      FLSH);
    add("md_recover",      1'b0, I0,      NORM);
`endif

    repeat (2) @(posedge clk);
    foreach (vecs[i]) step(vecs[i]);

`ifdef PIPE_CTRL_MD_EN
    // reset while draining the MD unit: sequence abandoned, counter cleared, no ack later
    begin
      vec_t h;
      h.rst = 1'b0; h.name = "w_start"; h.in = MS;  h.exp = NORM | B;  step(h);
      h.name = "w_irq";   h.in = IRQ; h.exp = NORM | B;  step(h);
      h.name = "w_wait";  h.in = I0;  h.exp = STALL | B; step(h);
      h.rst = 1'b1; h.name = "w_reset"; h.in = I0; h.exp = NORM; step(h);
      h.rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
        h.name = $sformatf("w_after_%0d", k); h.in = I0; h.exp = NORM; step(h);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
